// File: rtl/fft_input_loader_pkg.sv
// Shared FFT constants, loader state encoding and a width-parameterised bit-reverse helper.
package fft_input_loader_pkg;

  localparam int unsigned IN_BIT_DEF = 16;
  localparam int unsigned D_BIT_DEF  = 17;
  localparam int unsigned A_BIT_DEF  = 9;
  localparam int unsigned N_DEF      = 1 << (A_BIT_DEF + 2);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int unsigned REV_MAX = 32;
  localparam int unsigned REV_IW  = $clog2(REV_MAX);

  // Reverse the low 'width' bits of x; bits at or above 'width' come back as zero.
  function automatic logic [REV_MAX-1:0] bit_reverse(input logic [REV_MAX-1:0] x,
                                                     input int unsigned width);
    logic [REV_MAX-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < REV_MAX; i++) begin
      if (i < width) r[REV_IW'(width - 1 - i)] = x[REV_IW'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_addr.sv
// Maps a natural-order sample index to its bit-reversed {bank, address} location.
module fft_bitrev_addr
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned A_BIT = A_BIT_DEF
) (
  input  logic [A_BIT+1:0] n,
  output logic [1:0]       bank_c,
  output logic [A_BIT-1:0] addr_c
);

  localparam int unsigned NW = A_BIT + 2;

  logic [NW-1:0] rev;

  assign rev    = NW'(bit_reverse(REV_MAX'(n), NW));
  assign bank_c = rev[NW-1:A_BIT];
  assign addr_c = rev[A_BIT-1:0];

endmodule

// File: rtl/fft_input_loader.sv
// Streams one frame of complex samples into the 4-bank FFT memory in bit-reversed order.
module fft_input_loader
  import fft_input_loader_pkg::*;
#(
  parameter int unsigned IN_BIT = IN_BIT_DEF,
  parameter int unsigned D_BIT  = D_BIT_DEF,
  parameter int unsigned A_BIT  = A_BIT_DEF
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  input  logic              iVALID,
  input  logic [IN_BIT-1:0] iDATA_RE,
  input  logic [IN_BIT-1:0] iDATA_IM,
  output logic              oREADY,
  output logic [D_BIT-1:0]  oDATA_RE,
  output logic [D_BIT-1:0]  oDATA_IM,
  output logic [A_BIT-1:0]  oADDR_WR_0,
  output logic [A_BIT-1:0]  oADDR_WR_1,
  output logic [A_BIT-1:0]  oADDR_WR_2,
  output logic [A_BIT-1:0]  oADDR_WR_3,
  output logic              oWE_0,
  output logic              oWE_1,
  output logic              oWE_2,
  output logic              oWE_3,
  output logic              oBUSY,
  output logic              oDONE
);

  localparam int unsigned NW = A_BIT + 2;
  localparam logic [NW-1:0] N_LAST = '1;

  logic [1:0]       state, state_nxt;
  logic [NW-1:0]    n, n_nxt;
  logic             accept_c;
  logic [1:0]       bank_c;
  logic [A_BIT-1:0] addr_c;

  logic             ready_q, busy_q, done_q;
  logic [3:0]       we_q;
  logic [A_BIT-1:0] addr_q [4];
  logic [D_BIT-1:0] re_q, im_q;

  // The registered ready flag is high exactly in LOAD, so this is the handshake.
  assign accept_c = (state == ST_LOAD) && iVALID;

  fft_bitrev_addr #(.A_BIT(A_BIT)) u_bitrev (
    .n      (n),
    .bank_c (bank_c),
    .addr_c (addr_c)
  );

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      state <= ST_IDLE;
      n     <= '0;
    end else begin
      state <= state_nxt;
      n     <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    n_nxt     = n;
    case (state)
      ST_IDLE: begin
        if (iSTART) begin
          state_nxt = ST_LOAD;
          n_nxt     = '0;
        end
      end
      ST_LOAD: begin
        if (accept_c) begin
          n_nxt = n + NW'(1);
          if (n == N_LAST) state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Status flags follow the state being entered so they line up with it.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= (state_nxt == ST_LOAD);
      busy_q  <= (state_nxt != ST_IDLE);
      done_q  <= (state_nxt == ST_FLUSH);
    end
  end

  // Write port: data is shared by all banks, only the selected bank's address moves.
  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      we_q <= '0;
      re_q <= '0;
      im_q <= '0;
      for (int i = 0; i < 4; i++) addr_q[i] <= '0;
    end else begin
      we_q <= '0;
      if (accept_c) begin
        we_q[bank_c]   <= 1'b1;
        addr_q[bank_c] <= addr_c;
        re_q           <= D_BIT'(signed'(iDATA_RE));
        im_q           <= D_BIT'(signed'(iDATA_IM));
      end
    end
  end

  assign oREADY     = ready_q;
  assign oBUSY      = busy_q;
  assign oDONE      = done_q;
  assign oDATA_RE   = re_q;
  assign oDATA_IM   = im_q;
  assign oWE_0      = we_q[0];
  assign oWE_1      = we_q[1];
  assign oWE_2      = we_q[2];
  assign oWE_3      = we_q[3];
  assign oADDR_WR_0 = addr_q[0];
  assign oADDR_WR_1 = addr_q[1];
  assign oADDR_WR_2 = addr_q[2];
  assign oADDR_WR_3 = addr_q[3];

endmodule

// File: tb/tb_fft_input_loader.sv
// Self-checking bench: directed vector table, reset/restart sequence and a randomized full frame vs a reference model.
module tb_fft_input_loader;

  localparam int IN_BIT = 16;
  localparam int D_BIT  = 17;
  localparam int A_BIT  = 9;
  localparam int NB     = A_BIT + 2;
  localparam int N      = 1 << NB;
  localparam int DEPTH  = 1 << A_BIT;

  logic              iCLK = 1'b0;
  logic              iRESET = 1'b0;
  logic              iSTART = 1'b0;
  logic              iVALID = 1'b0;
  logic [IN_BIT-1:0] iDATA_RE = '0;
  logic [IN_BIT-1:0] iDATA_IM = '0;
  logic              oREADY, oBUSY, oDONE;
  logic [D_BIT-1:0]  oDATA_RE, oDATA_IM;
  logic [A_BIT-1:0]  oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
  logic              oWE_0, oWE_1, oWE_2, oWE_3;

  fft_input_loader dut (
    .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iVALID(iVALID),
    .iDATA_RE(iDATA_RE), .iDATA_IM(iDATA_IM), .oREADY(oREADY),
    .oDATA_RE(oDATA_RE), .oDATA_IM(oDATA_IM),
    .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
    .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
    .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
    .oBUSY(oBUSY), .oDONE(oDONE)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 idle, 1 loading, 2 final-write cycle.
  int m_phase = 0;
  int m_n = 0;
  int m_addr [4];
  int m_re = 0, m_im = 0;

  int hits [4][DEPTH];
  int bank_writes [4];
  int total_writes = 0;
  int done_pulses = 0;
  logic [3:0] done_we = '0;
  int done_addr3 = 0;

  typedef struct {
    logic        st;
    logic        v;
    logic [15:0] re;
    logic [15:0] im;
    logic        ready;
    logic [3:0]  we;
    int          addr;
    logic [16:0] dre;
    logic [16:0] dim;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bitrev(input int v);
    int r = 0;
    for (int i = 0; i < NB; i++) r = r * 2 + ((v >> i) & 1);
    return r;
  endfunction

  function automatic int sext(input int x);
    return (x >= (1 << (IN_BIT - 1))) ? x + ((1 << D_BIT) - (1 << IN_BIT)) : x;
  endfunction

  function automatic logic [3:0] we_vec();
    return {oWE_3, oWE_2, oWE_1, oWE_0};
  endfunction

  function automatic int addr_of(input int k);
    case (k)
      0: return int'(oADDR_WR_0);
      1: return int'(oADDR_WR_1);
      2: return int'(oADDR_WR_2);
      default: return int'(oADDR_WR_3);
    endcase
  endfunction

  function automatic int bank_of(input logic [3:0] we);
    case (we)
      4'b0001: return 0;
      4'b0010: return 1;
      4'b0100: return 2;
      default: return 3;
    endcase
  endfunction

  task automatic clear_stats();
    for (int k = 0; k < 4; k++) begin
      bank_writes[k] = 0;
      for (int a = 0; a < DEPTH; a++) hits[k][a] = 0;
    end
    total_writes = 0;
    done_pulses = 0;
  endtask

  // One clock with model update and full output comparison.
  task automatic cycle(input logic st, input logic v, input logic [15:0] re, input logic [15:0] im);
    bit acc;
    int r, b;
    logic [3:0] exp_we;
    iSTART = st; iVALID = v; iDATA_RE = re; iDATA_IM = im;
    @(posedge iCLK); #1;
    acc = (m_phase == 1) && v;
    exp_we = '0;
    if (acc) begin
      r = bitrev(m_n);
      b = r / DEPTH;
      exp_we[b] = 1'b1;
      m_addr[b] = r % DEPTH;
      m_re = sext(int'(re));
      m_im = sext(int'(im));
    end
    case (m_phase)
      0: if (st) begin m_phase = 1; m_n = 0; end
      1: if (acc) begin
           if (m_n == N - 1) m_phase = 2;
           m_n++;
         end
      default: m_phase = 0;
    endcase
    chk("ready", oREADY, m_phase == 1);
    chk("busy", oBUSY, m_phase != 0);
    chk("done", oDONE, m_phase == 2);
    chk("we", we_vec(), exp_we);
    for (int k = 0; k < 4; k++) chk($sformatf("addr%0d", k), addr_of(k), m_addr[k]);
    chk("data_re", oDATA_RE, m_re);
    chk("data_im", oDATA_IM, m_im);
    for (int k = 0; k < 4; k++) begin
      if (we_vec()[k]) begin
        hits[k][addr_of(k)]++;
        bank_writes[k]++;
        total_writes++;
      end
    end
    if (oDONE) begin
      done_pulses++;
      done_we = we_vec();
      done_addr3 = int'(oADDR_WR_3);
    end
  endtask

  // Asynchronous reset: outputs must clear before any clock edge.
  task automatic do_reset(input string tag);
    iSTART = 0; iVALID = 0;
    iRESET = 1'b1;
    #1;
    chk({tag, "_we"}, we_vec(), 4'b0000);
    chk({tag, "_ready"}, oREADY, 1'b0);
    chk({tag, "_busy"}, oBUSY, 1'b0);
    chk({tag, "_done"}, oDONE, 1'b0);
    m_phase = 0; m_n = 0; m_re = 0; m_im = 0;
    for (int k = 0; k < 4; k++) m_addr[k] = 0;
    @(posedge iCLK); #1;
    for (int k = 0; k < 4; k++) chk({tag, "_addr"}, addr_of(k), 0);
    chk({tag, "_dre"}, oDATA_RE, 0);
    chk({tag, "_dim"}, oDATA_IM, 0);
    iRESET = 1'b0;
  endtask

  initial begin
    int guard;
    bit ign_done, gap_done;
    int bad;
    int w_before;

    // Directed table: start, n=0..4, hold, ignored start, n=5.
    tbl[0] = '{1'b1, 1'b0, 16'h0000, 16'h0000, 1'b1, 4'b0000, 0,   17'h00000, 17'h00000};
    tbl[1] = '{1'b0, 1'b1, 16'h0001, 16'h0002, 1'b1, 4'b0001, 0,   17'h00001, 17'h00002};
    tbl[2] = '{1'b0, 1'b1, 16'h0003, 16'hFFFF, 1'b1, 4'b0100, 0,   17'h00003, 17'h1FFFF};
    tbl[3] = '{1'b0, 1'b1, 16'h7000, 16'h0004, 1'b1, 4'b0010, 0,   17'h07000, 17'h00004};
    tbl[4] = '{1'b0, 1'b1, 16'h0005, 16'h9000, 1'b1, 4'b1000, 0,   17'h00005, 17'h19000};
    tbl[5] = '{1'b0, 1'b1, 16'h8000, 16'h7FFF, 1'b1, 4'b0001, 256, 17'h18000, 17'h07FFF};
    tbl[6] = '{1'b0, 1'b0, 16'h1111, 16'h2222, 1'b1, 4'b0000, 0,   17'h18000, 17'h07FFF};
    tbl[7] = '{1'b1, 1'b0, 16'h3333, 16'h4444, 1'b1, 4'b0000, 0,   17'h18000, 17'h07FFF};
    tbl[8] = '{1'b0, 1'b1, 16'h1234, 16'hFEDC, 1'b1, 4'b0100, 256, 17'h01234, 17'h1FEDC};

    #2;
    do_reset("reset");

    for (int i = 0; i < 9; i++) begin
      iSTART = tbl[i].st; iVALID = tbl[i].v; iDATA_RE = tbl[i].re; iDATA_IM = tbl[i].im;
      @(posedge iCLK); #1;
      chk($sformatf("tbl%0d_ready", i), oREADY, tbl[i].ready);
      chk($sformatf("tbl%0d_we", i), we_vec(), tbl[i].we);
      if (tbl[i].we != 4'b0000)
        chk($sformatf("tbl%0d_addr", i), addr_of(bank_of(tbl[i].we)), tbl[i].addr);
      chk($sformatf("tbl%0d_dre", i), oDATA_RE, tbl[i].dre);
      chk($sformatf("tbl%0d_dim", i), oDATA_IM, tbl[i].dim);
    end

    // Reset at n=100, then restart from n=0.
    do_reset("resync");
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    for (int i = 0; i < 100; i++) cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    do_reset("midreset");
    cycle(1'b0, 1'b1, 16'h0, 16'h0);
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    cycle(1'b0, 1'b1, 16'h00AA, 16'h0055);
    chk("restart_we0", we_vec(), 4'b0001);
    chk("restart_addr0", oADDR_WR_0, 0);

    // Full randomized frame with gaps, an ignored start, backpressure and start in the done cycle.
    do_reset("frame");
    clear_stats();
    cycle(1'b1, 1'b0, 16'h0, 16'h0);
    guard = 0; ign_done = 0; gap_done = 0;
    while (m_phase != 0 && guard < 20000) begin
      if (m_phase == 2) begin
        cycle(1'b1, 1'b0, 16'($urandom), 16'($urandom));
      end else if (m_n == 500 && !ign_done) begin
        cycle(1'b1, 1'b1, 16'($urandom), 16'($urandom));
        ign_done = 1;
      end else if (m_n == 1000 && !gap_done) begin
        w_before = total_writes;
        for (int i = 0; i < 50; i++) cycle(1'b0, 1'b0, 16'($urandom), 16'($urandom));
        chk("gap_no_writes", total_writes - w_before, 0);
        gap_done = 1;
        guard += 50;
      end else begin
        cycle(1'b0, ($urandom_range(0, 99) >= 30), 16'($urandom), 16'($urandom));
      end
      guard++;
    end
    chk("frame_finished_in_budget", (guard < 20000), 1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 16'($urandom), 16'($urandom));
    chk("total_writes", total_writes, N);
    for (int k = 0; k < 4; k++) chk($sformatf("bank%0d_writes", k), bank_writes[k], DEPTH);
    bad = 0;
    for (int k = 0; k < 4; k++)
      for (int a = 0; a < DEPTH; a++)
        if (hits[k][a] != 1) bad++;
    chk("addr_hit_once", bad, 0);
    chk("done_pulses", done_pulses, 1);
    chk("done_we", done_we, 4'b1000);
    chk("done_addr3", done_addr3, DEPTH - 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_input_loader.md
Name: fft_input_loader

Overview:
- Upstream loader for the 4-bank FFT working memory (fft_ram_block).
- Accepts a serial stream of complex time-domain samples over a valid/ready handshake.
- Sign-extends each sample to the memory word width and writes it into the correct bank at the bit-reversed address, so the in-place FFT stages can start on bit-reversed data.
- Signals completion after exactly 4*2^A_BIT samples.

Parameters:
IN_BIT, 16, width of incoming signed real/imag samples
D_BIT, 17, memory word width; must be >= IN_BIT; guard bits come from sign extension
A_BIT, 9, address width per bank; frame length N = 2^(A_BIT+2) = 2048

Ports:
iCLK  in  1  system clock, rising edge
iRESET  in  1  asynchronous, active-high reset
iSTART  in  1  one-cycle pulse that arms a new frame load
iVALID  in  1  input sample valid
iDATA_RE  in  IN_BIT  signed real sample
iDATA_IM  in  IN_BIT  signed imaginary sample
oREADY  out  1  loader accepts a sample this cycle
oDATA_RE  out  D_BIT  sign-extended real write data, shared by all banks
oDATA_IM  out  D_BIT  sign-extended imaginary write data, shared by all banks
oADDR_WR_0..oADDR_WR_3  out  A_BIT each  per-bank write address
oWE_0..oWE_3  out  1 each  per-bank write enable
oBUSY  out  1  frame load in progress
oDONE  out  1  one-cycle pulse: last sample of the frame has been written

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE, sample counter n=0.
  - All outputs 0: oREADY, oBUSY, oDONE, every oWE_k, every oADDR_WR_k, oDATA_RE, oDATA_IM.
- FSM states: IDLE, LOAD, FLUSH.
  - IDLE: oREADY=0, oBUSY=0. When iSTART=1: clear n to 0, go to LOAD.
  - LOAD: oREADY=1, oBUSY=1. A sample is accepted when iVALID && oREADY; each acceptance increments n. On acceptance with n == N-1, go to FLUSH and drop oREADY on the next cycle.
  - FLUSH: one cycle, oBUSY=1, oREADY=0. The final write is on the outputs this cycle. Return to IDLE.
- oDONE: 1 in the same cycle as the final write (the FLUSH cycle), 0 otherwise.
- Address mapping for accepted sample index n (A_BIT+2 bits):
  - r = bit-reverse(n) over A_BIT+2 bits.
  - bank = r[A_BIT+1:A_BIT]; address = r[A_BIT-1:0].
  - Consecutive samples therefore rotate through banks 0,2,1,3. At most one oWE_k is high per cycle.
- Latency: exactly 1 cycle. Inputs accepted at edge t appear as registered oDATA_*, oADDR_WR_bank and oWE_bank=1 in the cycle after t.
- oWE_k is 0 whenever no sample was accepted on the previous edge.
- Idle outputs:
  - oADDR_WR_k and oDATA_* hold their last value when not written.
  - A bank's address is updated only when that bank is written.
- Width rule: oDATA_* = {(D_BIT-IN_BIT) copies of the input MSB, input}. No rounding, no saturation.
- Boundary conditions:
  - iSTART while in LOAD or FLUSH: ignored, no restart.
  - iVALID in IDLE or FLUSH: ignored, no write.
  - iVALID held low in LOAD: state and n hold indefinitely, no writes.
  - iSTART in the same cycle oDONE=1 (FLUSH): ignored. It must be reissued in IDLE.
  - Reset mid-LOAD: frame abandoned. Partially written memory contents are not cleared. oWE_k drop to 0 asynchronously.
  - Counter wrap: n never wraps inside a frame. It is cleared only on iSTART accepted in IDLE.

Decomposition:
- Shared package: FFT constants (D_BIT, A_BIT, derived N), LOADER state encoding, and a bit-reverse function parameterised by width, reused by the output unloader.
- One natural sub-module: fft_bitrev_addr. It is combinational, maps n to {bank, address}, and is instantiated once. Everything else stays in fft_input_loader.

Test Plan:
- Reset mid-operation: reset asserted at n=100 → all oWE_k=0 immediately, oREADY=0. After release, iSTART restarts from n=0 (first write goes to bank 0, address 0).
- Basic mapping: iSTART, then samples n=0..4 back-to-back. Required writes, each 1 cycle after acceptance:
  - n=0 → bank0 addr0
  - n=1 → bank2 addr0
  - n=2 → bank1 addr0
  - n=3 → bank3 addr0
  - n=4 → bank0 addr256
- Sign extension: iDATA_RE=16'h8000, iDATA_IM=16'h7FFF → oDATA_RE=17'h18000, oDATA_IM=17'h07FFF.
- Full frame with random iVALID gaps (~30% idle): exactly 2048 writes total, 512 per bank, each bank address hit once. oDONE is a single pulse coinciding with the n=2047 write (bank3 addr511). oBUSY falls the cycle after.
- Ignored events:
  - iSTART at n=500 → no restart, total writes stay 2048.
  - iVALID in IDLE → no oWE_k asserted.
  - iSTART during the oDONE cycle → stays IDLE.
- Backpressure: iVALID low for 50 cycles mid-frame → oREADY stays 1, no writes, n unchanged, and the load resumes correctly afterwards.
